led_s2p_rx: RTL and testbench



---
 rtl/led_s2p_rx.sv | 147 ++++++++++++++
 tb/tb_led_s2p_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_s2p_rx.sv
// led_s2p_rx: serial-to-parallel receiver for the LED shift-register link.
// Conditions the slow serial lines into the clk domain, shifts one frame in
// MSB first, ends the frame on an s_clk-high idle timeout and publishes the
// word with a one-cycle frame_valid strobe.
// Optional feature: define LED_S2P_RX_SYNC2_EN for a 2-flop synchronizer
// per serial input (default build uses a single register stage).
module led_s2p_rx #(
  parameter int DATA_W   = 16,
  parameter int IDLE_CYC = 1024,
  parameter int CNT_W    = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_clk,
  input  logic                        s_do_n,
  input  logic                        s_en,
  input  logic                        s_clr_n,
  output logic [DATA_W-1:0]           data,
  output logic                        frame_valid,
  output logic                        frame_err,
  output logic                        busy,
  output logic [$clog2(DATA_W)+1:0]   bit_cnt
);

  localparam int BC_W = $clog2(DATA_W) + 2;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [BC_W-1:0]  FULL_CNT  = BC_W'(DATA_W);
  // Idle levels of {s_clk, s_do_n, s_en, s_clr_n}
  localparam logic [3:0] SYNC_IDLE = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           sync_q;
  logic                 clk_s;
  logic                 do_n_s;
  logic                 en_s;
  logic                 clr_n_s;
  logic                 s_clk_prev;
  logic                 rise;
  logic                 rx_bit;
  logic [DATA_W-1:0]    shreg;
  logic [CNT_W-1:0]     idle_cnt;

`ifdef LED_S2P_RX_SYNC2_EN
  logic [3:0] sync_meta;

  // Two-flop synchronizer for the asynchronous serial inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= SYNC_IDLE;
      sync_q    <= SYNC_IDLE;
    end else begin
      sync_meta <= {s_clk, s_do_n, s_en, s_clr_n};
      sync_q    <= sync_meta;
    end
  end
`else
  // Single register stage for synchronous loopback / simulation
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= SYNC_IDLE;
    end else begin
      sync_q <= {s_clk, s_do_n, s_en, s_clr_n};
    end
  end
`endif

  assign {clk_s, do_n_s, en_s, clr_n_s} = sync_q;
  assign rise   = clk_s & ~s_clk_prev;
  assign rx_bit = ~do_n_s;

  // Receive FSM with registered outputs; the publish/error decision is taken
  // on the edge entering DONE so frame_valid is high exactly during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      s_clk_prev  <= 1'b1;
    end else begin
      s_clk_prev  <= clk_s;
      frame_valid <= 1'b0;

      // Clear first so a same-cycle publish below overrides it
      if (!clr_n_s) begin
        data      <= '0;
        frame_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise && en_s) begin
            shreg    <= {shreg[DATA_W-2:0], rx_bit};
            bit_cnt  <= BC_W'(1);
            idle_cnt <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (rise && en_s) begin
            shreg    <= {shreg[DATA_W-2:0], rx_bit};
            idle_cnt <= '0;
            if (bit_cnt != '1) begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end else if (idle_cnt == IDLE_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
            if (bit_cnt == FULL_CNT) begin
              data        <= shreg;
              frame_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (clk_s) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end else begin
            idle_cnt <= '0;
          end
        end

        DONE: begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_s2p_rx.sv
// Testbench for led_s2p_rx: directed frame table, reset-abort sequence and
// randomized frames checked against a frame-level reference model.
module tb_led_s2p_rx;

  localparam int DW  = 16;
  localparam int IC  = 40;
  localparam int CW  = 6;
  localparam int BCW = $clog2(DW) + 2;
`ifdef LED_S2P_RX_SYNC2_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_clk = 1'b1;
  logic           s_do_n = 1'b1;
  logic           s_en = 1'b0;
  logic           s_clr_n = 1'b1;
  logic [DW-1:0]  data;
  logic           frame_valid;
  logic           frame_err;
  logic           busy;
  logic [BCW-1:0] bit_cnt;

  led_s2p_rx #(
    .DATA_W   (DW),
    .IDLE_CYC (IC),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_clk       (s_clk),
    .s_do_n      (s_do_n),
    .s_en        (s_en),
    .s_clr_n     (s_clr_n),
    .data        (data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  int            pulses = 0;
  int            pulse_cyc = 0;
  logic [DW-1:0] pulse_data = '0;
  logic          busy_seen = 1'b0;
  always @(negedge clk) begin
    if (frame_valid) begin
      pulses     = pulses + 1;
      pulse_cyc  = cyc;
      pulse_data = data;
    end
    if (busy) busy_seen = 1'b1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model state: last published word and sticky error
  logic [DW-1:0] m_data = '0;
  logic          m_err  = 1'b0;
  int            last_edge = 0;

  task automatic shift_bits(input logic [31:0] val, input int n, input logic en);
    s_en = en;
    for (int i = n - 1; i >= 0; i--) begin
      s_clk  = 1'b0;
      s_do_n = ~val[i];
      step(4);
      s_clk     = 1'b1;
      last_edge = cyc;
      step(4);
    end
  endtask

  task automatic clear_pulse();
    s_clr_n = 1'b0;
    step(1);
    s_clr_n = 1'b1;
    step(SYNC + 2);
    m_data = '0;
    m_err  = 1'b0;
    chk("clr data", 32'(data), 32'(m_data));
    chk("clr err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic run_frame(input string tag, input logic [31:0] val, input int n, input logic en);
    int            p0;
    int            exp_p;
    int            exp_cnt;
    logic [31:0]   word;
    logic          bits_q[$];
    p0        = pulses;
    busy_seen = 1'b0;
    shift_bits(val, n, en);
    exp_cnt = en ? ((n > (2**BCW) - 1) ? (2**BCW) - 1 : n) : 0;
    chk({tag, " mid bit_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
    step(IC + SYNC + 6);
    s_en = 1'b0;
    // Frame-level model: only enabled edges deliver bits
    exp_p = 0;
    if (en) begin
      for (int i = n - 1; i >= 0; i--) bits_q.push_back(val[i]);
      if (bits_q.size() == DW) begin
        word = 0;
        foreach (bits_q[k]) word = word * 2 + 32'(bits_q[k]);
        m_data = word[DW-1:0];
        exp_p  = 1;
      end else begin
        m_err = 1'b1;
      end
    end
    chk({tag, " pulses"}, 32'(pulses - p0), 32'(exp_p));
    chk({tag, " data"}, 32'(data), 32'(m_data));
    chk({tag, " err"}, 32'(frame_err), 32'(m_err));
    chk({tag, " busy_seen"}, 32'(busy_seen), 32'(en));
    chk({tag, " end bit_cnt"}, 32'(bit_cnt), 32'd0);
    if (exp_p == 1) begin
      chk({tag, " latency"}, 32'(pulse_cyc - last_edge), 32'(SYNC + IC + 1));
      chk({tag, " pulse data"}, 32'(pulse_data), 32'(m_data));
    end
  endtask

  typedef struct {
    logic [31:0]   val;
    int            n;
    logic          en;
    logic          clr_before;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{32'h0000_A5C3, 16, 1'b1, 1'b0, 16'hA5C3, 1'b0};
    tbl[1] = '{32'h0000_7FFF, 15, 1'b1, 1'b0, 16'hA5C3, 1'b1};
    tbl[2] = '{32'h0003_1234, 18, 1'b1, 1'b1, 16'h0000, 1'b1};
    tbl[3] = '{32'h0000_0F0F, 16, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[4] = '{32'h0000_0F0F, 16, 1'b1, 1'b0, 16'h0F0F, 1'b0};

    // Reset state
    rst = 1'b1;
    step(3);
    chk("rst data", 32'(data), 32'd0);
    chk("rst valid", 32'(frame_valid), 32'd0);
    chk("rst err", 32'(frame_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bit_cnt", 32'(bit_cnt), 32'd0);
    rst = 1'b0;
    step(4);
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst pulses", 32'(pulses), 32'd0);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      if (tbl[v].clr_before) clear_pulse();
      run_frame($sformatf("tbl%0d", v), tbl[v].val, tbl[v].n, tbl[v].en);
      chk($sformatf("tbl%0d exp data", v), 32'(data), 32'(tbl[v].exp_data));
      chk($sformatf("tbl%0d exp err", v), 32'(frame_err), 32'(tbl[v].exp_err));
    end

    // Reset in the middle of a frame discards it
    begin
      int p0;
      p0 = pulses;
      shift_bits(32'h0000_FFFF, 8, 1'b1);
      chk("abort mid bit_cnt", 32'(bit_cnt), 32'd8);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort bit_cnt", 32'(bit_cnt), 32'd0);
      chk("abort data", 32'(data), 32'd0);
      m_data = '0;
      m_err  = 1'b0;
      step(IC + SYNC + 6);
      chk("abort pulses", 32'(pulses - p0), 32'd0);
      chk("abort err", 32'(frame_err), 32'd0);
      run_frame("after abort", 32'h0000_0F0F, 16, 1'b1);
    end

    // Randomized frames against the model
    for (int r = 0; r < 24; r++) begin
      logic [31:0] val;
      int          n;
      logic        en;
      val = $urandom;
      n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(13, 19)) : DW;
      en  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) clear_pulse();
      run_frame($sformatf("rnd%0d", r), val, n, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
